serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that feeds the existing single-bit full_adder one operand bit pair per clock, LSB first.
- Holds the running carry in a flip-flop between bits.
- Wraps the combinational full_adder with operand shift registers, a bit counter and a start/done handshake.
- Trades WIDTH cycles of latency for a single adder cell.
- Sits between the lab's operand source (switches or register file) and the result display/register.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new addition; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; captured only on an accepted start.
- b  input  WIDTH  operand B; captured only on an accepted start.
- cin  input  1  carry-in; captured only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  registered result; stable between done pulses.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset: rst_n low forces the following immediately (asynchronous), regardless of clk:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0
  - shift registers, bit counter and carry flop = 0
- rst_n deassertion takes effect from the next rising edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at an edge: load sh_a <= a, sh_b <= b, carry <= cin, cnt <= 0, go to RUN.
- RUN (busy = 1, done = 0), at each edge:
  - The full_adder instance computes on sh_a[0], sh_b[0], carry.
  - carry <= full_adder cout.
  - The full_adder sum bit is shifted into the MSB of sh_s; sh_s shifts right.
  - sh_a and sh_b shift right.
  - cnt <= cnt + 1.
- RUN exit: at the edge where cnt == WIDTH-1:
  - sum <= completed sh_s (sum bit included).
  - cout <= full_adder cout.
  - Go to DONE.
- RUN start handling: start is ignored; operands are not reloaded.
- DONE:
  - busy = 0, done = 1 for exactly one cycle.
  - start = 1 at the DONE edge: accepted exactly as in IDLE (go to RUN); back-to-back operations have no idle gap.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k → done high from edge k+WIDTH to edge k+WIDTH+1; sum/cout valid from edge k+WIDTH.
- Result hold: sum/cout keep the previous result throughout RUN. They change only at the RUN→DONE edge or on reset.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Operand stability: a, b and cin may change freely after the accepting edge without affecting the result.
- Counter width: clog2(WIDTH)+1 bits; it must not wrap before WIDTH-1 is reached.
- Reset mid-operation: the in-flight operation is discarded and no done pulse is produced. The next start behaves as the first after power-up.
- WIDTH = 1: RUN lasts one cycle; done at edge k+1.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed at edge 0:
  - busy high for edges 1-8.
  - done pulse at edge 8 → sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, exactly 8 cycles after start.
- a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 → sum=0x00, cout=0.
- Start 0x12+0x34; pulse start with a=0xFF, b=0xFF at cycle 3 of RUN:
  - Result is 0x46, cout=0; the second start is ignored.
  - sum holds the prior value until done.
- Assert rst_n low at cycle 4 of an operation:
  - All outputs are 0 immediately (mid-cycle, before the next edge).
  - No done pulse follows.
  - A fresh start after release gives the correct result.
- Hold start high continuously with operands changing each operation:
  - done every 9 cycles (8 RUN + 1 DONE).
  - Each result matches the operands sampled at its accepting edge.
- Exhaustive random 1000 operations vs golden model a+b+cin; repeat at WIDTH=1 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single full_adder cell.
// Operands are captured on an accepted start and processed LSB first, one bit
// per clock, with the running carry held in a flop between bits.
// {cout, sum} = a + b + cin, produced WIDTH cycles after the accepting edge.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // One extra bit so the counter can hold WIDTH-1 without wrapping.
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sh_s_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Shift the new sum bit in at the MSB; written as a widened shift so that
    // WIDTH = 1 needs no special case.
    assign sh_s_next = WIDTH'({fa_s, sh_s} >> 1);

    // Control FSM with registered handshake outputs and the serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= fa_c;
                    sh_s  <= sh_s_next;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= sh_s_next;
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 1 and 16.
// One shared set of stimulus signals is steered to the selected instance.

module tb_serial_adder;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic        cin;
    int unsigned sel;

    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy1, done1, cout1;
    logic [0:0]  sum1;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    logic        busy_m, done_m, cout_m;
    logic [31:0] sum_m;

    int checks;
    int errors;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1),
        .a(a_bus[0:0]), .b(b_bus[0:0]), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    always_comb begin
        busy_m = 1'b0; done_m = 1'b0; cout_m = 1'b0; sum_m = '0;
        case (sel)
            0: begin busy_m = busy8;  done_m = done8;  cout_m = cout8;  sum_m = {24'd0, sum8};  end
            1: begin busy_m = busy1;  done_m = done1;  cout_m = cout1;  sum_m = {31'd0, sum1};  end
            default: begin busy_m = busy16; done_m = done16; cout_m = cout16; sum_m = {16'd0, sum16}; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned width_of(input int unsigned s);
        return (s == 0) ? 8 : (s == 1) ? 1 : 16;
    endfunction

    // One full operation on the selected instance; caller is 1 ns after an edge.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic ci, input string nm);
        int unsigned w;
        longint unsigned m, ev, es, ec;
        int n;
        bit got;
        w  = width_of(sel);
        m  = (64'd1 << w) - 1;
        ev = (longint'(av) & m) + (longint'(bv) & m) + longint'(ci);
        es = ev & m;
        ec = (ev >> w) & 1;
        start = 1'b1; a_bus = av; b_bus = bv; cin = ci;
        @(posedge clk); #1;
        start = 1'b0; a_bus = $urandom; b_bus = $urandom; cin = 1'($urandom);
        n = 0; got = 0;
        while (!got && n < int'(w) + 4) begin
            checks++;
            if (busy_m !== 1'b1) begin
                errors++; $display("FAIL %s busy: got %b want 1 (cycle %0d)", nm, busy_m, n);
            end
            @(posedge clk); #1;
            n++;
            if (done_m === 1'b1) got = 1;
        end
        checks++;
        if (!got || n != int'(w)) begin
            errors++; $display("FAIL %s latency: got %0d cycles (done seen %0b) want %0d", nm, n, got, w);
        end
        checks++;
        if (busy_m !== 1'b0) begin
            errors++; $display("FAIL %s busy_at_done: got %b want 0", nm, busy_m);
        end
        checks++;
        if (sum_m !== es[31:0]) begin
            errors++; $display("FAIL %s sum: got %h want %h", nm, sum_m, es[31:0]);
        end
        checks++;
        if (cout_m !== ec[0]) begin
            errors++; $display("FAIL %s cout: got %b want %b", nm, cout_m, ec[0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_bus = '0; b_bus = '0; cin = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int unsigned s = 0; s < 3; s++) begin
            sel = s; #0.1;
            checks++;
            if ({busy_m, done_m, cout_m} !== 3'b000 || sum_m !== 32'd0) begin
                errors++; $display("FAIL reset_w%0d: got busy=%b done=%b cout=%b sum=%h want all 0",
                                   width_of(s), busy_m, done_m, cout_m, sum_m);
            end
        end
        sel = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        sel = 0;
        do_op(32'h5A, 32'h3C, 1'b0, "add_5a_3c");
        @(posedge clk); #1;
        checks++;
        if (done_m !== 1'b0) begin
            errors++; $display("FAIL done_single_pulse: got %b want 0", done_m);
        end
        do_op(32'hFF, 32'h01, 1'b0, "add_ff_01");
        do_op(32'hFF, 32'h00, 1'b1, "add_ff_00_c");
        do_op(32'h00, 32'h00, 1'b0, "add_zero");
        do_op(32'hFF, 32'hFF, 1'b1, "add_max");
    endtask

    task automatic test_start_ignored();
        int n;
        bit got;
        sel = 0;
        do_op(32'h50, 32'h21, 1'b0, "pre_71");
        @(posedge clk); #1;
        start = 1'b1; a_bus = 32'h12; b_bus = 32'h34; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 0;
        while (!got && n < 12) begin
            if (n == 3) begin
                start = 1'b1; a_bus = 32'hFF; b_bus = 32'hFF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            checks++;
            if (sum_m !== 32'h71 || cout_m !== 1'b0) begin
                errors++; $display("FAIL hold_prev: got sum=%h cout=%b want 71/0 (cycle %0d)", sum_m, cout_m, n);
            end
            @(posedge clk); #1;
            n++;
            if (done_m === 1'b1) got = 1;
        end
        start = 1'b0;
        checks++;
        if (!got || n != 8 || sum_m !== 32'h46 || cout_m !== 1'b0) begin
            errors++; $display("FAIL start_ignored: got cycles=%0d sum=%h cout=%b want 8/46/0", n, sum_m, cout_m);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_m !== 1'b0) begin
            errors++; $display("FAIL start_ignored_no_rerun: got busy=%b want 0", busy_m);
        end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        start = 1'b1; a_bus = 32'h0F; b_bus = 32'h0F; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_m, done_m, cout_m} !== 3'b000 || sum_m !== 32'd0) begin
            errors++; $display("FAIL reset_mid_async: got busy=%b done=%b cout=%b sum=%h want all 0",
                               busy_m, done_m, cout_m, sum_m);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done_m !== 1'b0 || busy_m !== 1'b0) begin
                errors++; $display("FAIL reset_mid_quiet: got done=%b busy=%b want 0/0 (cycle %0d)", done_m, busy_m, i);
            end
        end
        do_op(32'hA7, 32'h6B, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa [5];
        logic [31:0] ob [5];
        logic        oc [5];
        longint unsigned ev;
        int n;
        bit got;
        sel = 0;
        for (int i = 0; i < 5; i++) begin
            oa[i] = $urandom & 32'hFF; ob[i] = $urandom & 32'hFF; oc[i] = 1'($urandom);
        end
        start = 1'b1; a_bus = oa[0]; b_bus = ob[0]; cin = oc[0];
        @(posedge clk); #1;
        a_bus = oa[1]; b_bus = ob[1]; cin = oc[1];
        for (int i = 0; i < 5; i++) begin
            n = 0; got = 0;
            while (!got && n < 12) begin
                @(posedge clk); #1;
                n++;
                if (done_m === 1'b1) got = 1;
            end
            ev = longint'(oa[i]) + longint'(ob[i]) + longint'(oc[i]);
            checks++;
            if (!got || n != 8 || sum_m !== 32'(ev & 64'hFF) || cout_m !== ev[8]) begin
                errors++; $display("FAIL b2b_op%0d: got cycles=%0d sum=%h cout=%b want 8/%h/%b",
                                   i, n, sum_m, cout_m, 32'(ev & 64'hFF), ev[8]);
            end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (done_m !== 1'b0 || busy_m !== (i < 4)) begin
                errors++; $display("FAIL b2b_gap%0d: got done=%b busy=%b want 0/%b", i, done_m, busy_m, i < 4);
            end
            if (i + 2 < 5) begin
                a_bus = oa[i+2]; b_bus = ob[i+2]; cin = oc[i+2];
            end
        end
    endtask

    task automatic test_random(input int unsigned s, input int count);
        sel = s;
        @(posedge clk); #1;
        for (int i = 0; i < count; i++) begin
            do_op($urandom, $urandom, 1'($urandom), $sformatf("rand_w%0d_%0d", width_of(s), i));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random(0, 1000);
        test_random(1, 1000);
        test_random(2, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
